// File: rtl/sa_ram_rd_pkg.sv
// Shared constants and the response entry type for the sa_ram read streamer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sa_ram_rd_pkg;

    localparam int DEFAULT_DW         = 80;
    localparam int DEFAULT_AW         = 5;
    localparam int DEFAULT_RAM_DEPTH  = 19;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // One response as it sits in the skid FIFO. The data field is sized for
    // the default RAM width; a streamer instance must not use a wider DW.
    typedef struct packed {
        logic                  err;
        logic [DEFAULT_DW-1:0] data;
    } rd_entry_t;

    // Bits needed to hold a count in the range 0..max_val.
    function automatic int cnt_w(input int max_val);
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/sa_ram_rd_skid_fifo.sv
// Synchronous circular FIFO with an occupancy count; fall-through is the parent's job.
// Latency: a pushed entry is visible at head_dat the cycle after the push.
// Backpressure: none internally; the parent's credit scheme guarantees no overflow.
//
// Ports: clk/reset (sync, active-high); push/push_dat write the tail;
//        pop advances the head; head_dat, count and empty describe the state.
module sa_ram_rd_skid_fifo
    import sa_ram_rd_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [W-1:0]             push_dat,
    input  logic                     pop,
    output logic [W-1:0]             head_dat,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = cnt_w(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Storage needs no reset: only entries below count are ever presented.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);

endmodule

// File: rtl/sa_ram_rd_stream.sv
// Read-side controller for a two-stage registered-read RAM: request stream in, in-order data stream out.
// Latency: 2 cycles from request accept to rsp_valid when the FIFO is empty and rsp_ready is high.
// Backpressure: req_ready is a registered credit (FIFO + in-flight < FIFO_DEPTH), so stalled reads always land in the skid FIFO.
//
// Ports: req_valid/req_ready/req_addr request stream; rsp_valid/rsp_ready/rsp_data/rsp_err
//        response stream (err = address out of range, data forced to zero);
//        ram_ra/ram_re/ram_ore/ram_dout/ram_byp_sel/ram_dbyp drive the RAM read port.
module sa_ram_rd_stream
    import sa_ram_rd_pkg::*;
#(
    parameter int DW         = DEFAULT_DW,
    parameter int AW         = DEFAULT_AW,
    parameter int RAM_DEPTH  = DEFAULT_RAM_DEPTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [AW-1:0] req_addr,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] ram_ra,
    output logic          ram_re,
    output logic          ram_ore,
    input  logic [DW-1:0] ram_dout,
    output logic          ram_byp_sel,
    output logic [DW-1:0] ram_dbyp
);

    localparam int CW = cnt_w(FIFO_DEPTH);
    // FIFO count plus the two pipeline stage bits.
    localparam int SW = cnt_w(FIFO_DEPTH + 2);

    logic            s1_vld;
    logic            s1_err;
    logic            s2_vld;
    logic            s2_err;
    logic            ready_q;
    logic            accept;
    logic            in_range;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [CW-1:0]   count_nxt;
    logic [SW-1:0]   credit_nxt;
    rd_entry_t       s2_entry;
    rd_entry_t       head_entry;
    rd_entry_t       rsp_entry;

    // ---------------- request side ----------------
    assign in_range  = (32'(req_addr) < RAM_DEPTH);
    assign accept    = req_valid & ready_q;
    assign req_ready = ready_q;

    // Out-of-range requests never touch the RAM; ra is parked at zero when idle.
    assign ram_re      = accept & in_range;
    assign ram_ra      = ram_re ? req_addr : '0;
    assign ram_ore     = s1_vld & ~s1_err;
    assign ram_byp_sel = 1'b0;
    assign ram_dbyp    = '0;

    // ---------------- S2 response formation ----------------
    always_comb begin
        s2_entry      = '0;
        s2_entry.err  = s2_vld & s2_err;
        s2_entry.data = (s2_vld && !s2_err) ? DEFAULT_DW'(ram_dout) : '0;
    end

    // The FIFO head is always older than S2, so it has priority. S2 bypasses
    // the FIFO only when nothing is queued and the consumer takes it now;
    // otherwise it is pushed so the same values reappear from the head.
    assign fifo_pop  = ~fifo_empty & rsp_ready;
    assign fifo_push = s2_vld & ~(fifo_empty & rsp_ready);

    assign rsp_valid = ~fifo_empty | s2_vld;

    always_comb begin
        rsp_entry = fifo_empty ? s2_entry : head_entry;
        rsp_data  = DW'(rsp_entry.data);
        rsp_err   = rsp_entry.err;
    end

    sa_ram_rd_skid_fifo #(
        .W     ($bits(rd_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (fifo_push),
        .push_dat (s2_entry),
        .pop      (fifo_pop),
        .head_dat (head_entry),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    // ---------------- credit ----------------
    // req_ready is registered from the next-cycle occupancy, which equals the
    // credit rule evaluated on registered terms and keeps rsp_ready off the
    // req_ready output path. Next S1 = this accept, next S2 = current S1.
    assign count_nxt  = fifo_count + CW'(fifo_push) - CW'(fifo_pop);
    assign credit_nxt = SW'(count_nxt) + SW'(accept) + SW'(s1_vld);

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s1_err  <= 1'b0;
            s2_vld  <= 1'b0;
            s2_err  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            s1_vld  <= accept;
            s1_err  <= accept & ~in_range;
            s2_vld  <= s1_vld;
            s2_err  <= s1_err;
            ready_q <= (credit_nxt < SW'(FIFO_DEPTH));
        end
    end

endmodule

// File: tb/tb_sa_ram_rd_stream.sv
// Bench for sa_ram_rd_stream: RAM read-port model, reference queue of outstanding reads,
// per-cycle comparison of every DUT output, plus literal checks for the directed tests.
module tb_sa_ram_rd_stream;

    localparam int DW     = 80;
    localparam int AW     = 5;
    localparam int RDEPTH = 19;
    localparam int FDEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic [AW-1:0] ram_ra;
    logic          ram_re;
    logic          ram_ore;
    logic [DW-1:0] ram_dout;
    logic          ram_byp_sel;
    logic [DW-1:0] ram_dbyp;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int rdy_mode = 0;   // 0: rsp_ready high, 1: low, 2: random

    always #5 clk = ~clk;

    sa_ram_rd_stream #(
        .DW(DW), .AW(AW), .RAM_DEPTH(RDEPTH), .FIFO_DEPTH(FDEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .ram_ra      (ram_ra),
        .ram_re      (ram_re),
        .ram_ore     (ram_ore),
        .ram_dout    (ram_dout),
        .ram_byp_sel (ram_byp_sel),
        .ram_dbyp    (ram_dbyp)
    );

    // ---------------- RAM model: re latches address, ore latches data ----------------
    function automatic logic [DW-1:0] ram_val(input int i);
        return {8'hA5, 8'(i), 64'h0123_4567_89AB_CDEF ^ 64'(i)};
    endfunction

    logic [DW-1:0] mem [0:31];
    logic [AW-1:0] ram_addr_r = '0;
    logic [DW-1:0] ram_dout_r = '0;

    initial for (int i = 0; i < 32; i++) mem[i] = ram_val(i);

    always @(posedge clk) begin
        if (ram_re)  ram_addr_r <= ram_ra;
        if (ram_ore) ram_dout_r <= mem[ram_addr_r];
    end
    assign ram_dout = ram_byp_sel ? ram_dbyp : ram_dout_r;

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic          err;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t exp_q[$];   // accepted, not yet consumed
    exp_t got_q[$];   // consumed responses, in order
    exp_t e;

    bit            started = 0;
    bit            prev_rst = 0;
    bit            prev_acc_inr = 0;
    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic          prev_err;
    logic          c_acc;
    logic          c_inr;
    logic          c_due;

    // rsp_ready driver
    initial begin
        rsp_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Compare process: every output every cycle, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (started && prev_rst) begin
                chk("rst_req_ready", 81'(req_ready), 81'(0));
                chk("rst_rsp_valid", 81'(rsp_valid), 81'(0));
                chk("rst_rsp_err",   81'(rsp_err),   81'(0));
                chk("rst_rsp_data",  81'(rsp_data),  81'(0));
                chk("rst_ram_re",    81'(ram_re),    81'(0));
                chk("rst_ram_ore",   81'(ram_ore),   81'(0));
                chk("rst_ram_ra",    81'(ram_ra),    81'(0));
            end else if (started) begin
                c_acc = req_valid & req_ready;
                c_inr = (req_addr < AW'(RDEPTH));
                // Outstanding reads = accepted minus consumed; credit is that < depth.
                chk("req_ready_credit", 81'(req_ready), 81'(exp_q.size() < FDEPTH));
                chk("ram_re", 81'(ram_re), 81'(c_acc & c_inr));
                if (c_acc && c_inr) chk("ram_ra", 81'(ram_ra), 81'(req_addr));
                chk("ram_ore", 81'(ram_ore), 81'(prev_acc_inr));
                chk("ram_byp_sel", 81'(ram_byp_sel), 81'(0));
                chk("ram_dbyp", 81'(ram_dbyp), 81'(0));
                // Oldest outstanding read is presented once it is 2 cycles old.
                c_due = (exp_q.size() > 0) && (cyc - exp_q[0].cyc >= 2);
                chk("rsp_valid", 81'(rsp_valid), 81'(c_due));
                if (rsp_valid && c_due) begin
                    chk("rsp_data", 81'(rsp_data), 81'(exp_q[0].data));
                    chk("rsp_err",  81'(rsp_err),  81'(exp_q[0].err));
                end
                if (prev_stall) begin
                    chk("hold_valid", 81'(rsp_valid), 81'(1));
                    chk("hold_data",  81'(rsp_data),  81'(prev_data));
                    chk("hold_err",   81'(rsp_err),   81'(prev_err));
                end
                if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
                    e.err = rsp_err; e.data = rsp_data; e.cyc = cyc;
                    got_q.push_back(e);
                    void'(exp_q.pop_front());
                end
                if (c_acc) begin
                    e.err  = !c_inr;
                    e.data = c_inr ? ram_val(int'(req_addr)) : '0;
                    e.cyc  = cyc;
                    exp_q.push_back(e);
                end
                prev_acc_inr = c_acc & c_inr;
                prev_stall   = rsp_valid & !rsp_ready;
                prev_data    = rsp_data;
                prev_err     = rsp_err;
            end
            if (reset) begin
                exp_q.delete();
                prev_acc_inr = 0;
                prev_stall   = 0;
                started      = 1;
            end
            prev_rst = reset;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request and hold it until accepted (bounded).
    task automatic send(input int a);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_addr  = AW'(a);
        @(negedge clk);
        while (!req_ready && n < 100) begin
            step();
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            fails++;
            $display("FAIL send_timeout: addr %0d not accepted after %0d cycles", a, n);
        end
        step();
        req_valid = 1'b0;
    endtask

    int acc;
    int a;
    int n;
    int g0;

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        repeat (3) step();
        reset = 1'b0;
        repeat (5) step();

        // Test 1: single read of addr 3, 2-cycle latency, literal data.
        req_valid = 1'b1;
        req_addr  = 5'd3;
        @(negedge clk);
        chk("t1_ram_re", 81'(ram_re), 81'(1));
        chk("t1_ram_ra", 81'(ram_ra), 81'(3));
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("t1_ram_ore",   81'(ram_ore),   81'(1));
        chk("t1_rsp_early", 81'(rsp_valid), 81'(0));
        step();
        @(negedge clk);
        chk("t1_rsp_valid", 81'(rsp_valid), 81'(1));
        chk("t1_rsp_data",  81'(rsp_data),  81'(80'hA5_03_0123_4567_89AB_CDEC));
        chk("t1_rsp_err",   81'(rsp_err),   81'(0));
        step();

        // Test 2: 19 back-to-back reads.
        g0 = got_q.size();
        for (int i = 0; i < RDEPTH; i++) send(i);
        repeat (4) step();
        chk("t2_count", 81'(got_q.size() - g0), 81'(19));
        chk("t2_last",  81'(got_q[got_q.size()-1].data), 81'(80'hA5_12_0123_4567_89AB_CDFD));

        // Test 3: consumer stalled, credit caps acceptance at FIFO depth.
        rdy_mode = 1;
        step();
        acc = 0;
        a   = 0;
        req_valid = 1'b1;
        req_addr  = AW'(a);
        repeat (8) begin
            @(negedge clk);
            if (req_ready) begin acc++; a++; end
            step();
            req_addr = AW'(a);
        end
        req_valid = 1'b0;
        chk("t3_accepts", 81'(acc), 81'(4));
        @(negedge clk);
        chk("t3_ready_low", 81'(req_ready), 81'(0));
        g0 = got_q.size();
        rdy_mode = 0;
        repeat (8) step();
        @(negedge clk);
        chk("t3_ready_back", 81'(req_ready), 81'(1));
        chk("t3_drained",    81'(got_q.size() - g0), 81'(4));
        chk("t3_first",      81'(got_q[g0].data), 81'(80'hA5_00_0123_4567_89AB_CDEF));
        step();

        // Test 4: out-of-range request between two valid ones.
        send(2);
        send(19);
        send(5);
        repeat (4) step();
        n = got_q.size();
        chk("t4_a2_data",  81'(got_q[n-3].data), 81'(80'hA5_02_0123_4567_89AB_CDED));
        chk("t4_a2_err",   81'(got_q[n-3].err),  81'(0));
        chk("t4_a19_data", 81'(got_q[n-2].data), 81'(0));
        chk("t4_a19_err",  81'(got_q[n-2].err),  81'(1));
        chk("t4_a5_data",  81'(got_q[n-1].data), 81'(80'hA5_05_0123_4567_89AB_CDEA));
        chk("t4_a5_err",   81'(got_q[n-1].err),  81'(0));

        // Test 5: 200 requests (some out of range) with a random consumer.
        g0 = got_q.size();
        rdy_mode = 2;
        for (int i = 0; i < 200; i++) send(i % 24);
        rdy_mode = 0;
        repeat (10) step();
        chk("t5_count",   81'(got_q.size() - g0), 81'(200));
        chk("t5_pending", 81'(exp_q.size()),      81'(0));

        // Test 6: reset with 2 reads in the pipeline and 2 in the FIFO.
        rdy_mode = 1;
        step();
        for (int i = 0; i < 4; i++) send(10 + i);
        reset = 1'b1;
        step();
        @(negedge clk);
        chk("t6_rsp_valid", 81'(rsp_valid), 81'(0));
        chk("t6_ram_ore",   81'(ram_ore),   81'(0));
        step();
        reset    = 1'b0;
        rdy_mode = 0;
        g0 = got_q.size();
        send(7);
        @(negedge clk);
        chk("t6_rsp_early", 81'(rsp_valid), 81'(0));
        chk("t6_ram_ore2",  81'(ram_ore),   81'(1));
        step();
        @(negedge clk);
        chk("t6_rsp_valid2", 81'(rsp_valid), 81'(1));
        chk("t6_rsp_data",   81'(rsp_data),  81'(80'hA5_07_0123_4567_89AB_CDE8));
        chk("t6_rsp_err",    81'(rsp_err),   81'(0));
        repeat (4) step();
        chk("t6_only_one", 81'(got_q.size() - g0), 81'(1));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/sa_ram_rd_stream.md
Name: sa_ram_rd_stream

Overview:
- Read-side controller for the sa_ram_rwsthp_* RAM models (two-stage registered read: `re` latches the address, `ore` latches the data).
- Accepts read requests on a valid/ready address stream, sequences `re`/`ore` into the RAM, and returns data in order on a valid/ready response stream.
- A small credit-guarded skid FIFO ensures no in-flight read is ever lost under backpressure.
- Sits between a consumer engine and the RAM read port. The write port is owned by a separate writer.

Parameters:
- DW, 80, data width (matches RAM `dout`)
- AW, 5, address width (matches RAM `ra`)
- RAM_DEPTH, 19, number of valid RAM entries
- FIFO_DEPTH, 4, response skid FIFO entries (minimum 2)

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  read request valid
- req_ready  out  1  read request accepted when valid&ready
- req_addr  in  AW  read address
- rsp_valid  out  1  read data valid
- rsp_ready  in  1  consumer accepts data
- rsp_data  out  DW  read data
- rsp_err  out  1  request address was >= RAM_DEPTH; data is zero
- ram_ra  out  AW  to RAM `ra`
- ram_re  out  1  to RAM `re`
- ram_ore  out  1  to RAM `ore`
- ram_dout  in  DW  from RAM `dout`
- ram_byp_sel  out  1  to RAM `byp_sel`, constant 0
- ram_dbyp  out  DW  to RAM `dbyp`, constant 0

Interface decision: one clock (clk); reset is synchronous and active-high (reset).

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, ram_re=0, ram_ore=0, ram_ra=0.
  - Pipeline valids and FIFO pointers/count are cleared.
  - req_ready rises in the first cycle after reset deasserts.
- Pipeline: stage S1 (address latched in RAM) and stage S2 (data latched in RAM dout_r). Each stage has a valid bit and an err bit.
- Accept in cycle N (req_valid & req_ready):
  - In-range address: ram_re=1 and ram_ra=req_addr combinationally in cycle N. S1 valid in N+1.
  - req_addr >= RAM_DEPTH: ram_re=0 (RAM not touched); the token still travels S1/S2 with err=1.
- Cycle N+1: ram_ore=1 iff S1 valid and not err. S2 valid in N+2.
- Cycle N+2, response formation:
  - Data = ram_dout, or 0 if err.
  - FIFO empty and rsp_ready=1: data goes to rsp_* directly (fall-through). Latency from accept to rsp_valid is 2 cycles.
  - Otherwise: data is written to the FIFO tail.
- Ordering: responses are strictly in request order. FIFO entries are always presented before fall-through data.
- ram_ore is 0 whenever S1 is invalid, so RAM dout_r holds and is never sampled outside S2.
- Credit rule: req_ready = (fifo_count + S1v + S2v) < FIFO_DEPTH.
  - Uses registered terms only; there is no combinational path from rsp_ready to req_ready.
- rsp_valid = FIFO non-empty or (S2 valid and FIFO empty). rsp_data/rsp_err are driven from the FIFO head, else from S2.
- Data stability: once rsp_valid=1, rsp_data/rsp_err/rsp_valid hold until rsp_ready. When S2 is presented unaccepted it is pushed to the FIFO in the same cycle, keeping the same values next cycle.
- Simultaneous FIFO push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Full throughput: with rsp_ready held high, one request per cycle is sustained indefinitely.
- Reset mid-operation: all in-flight S1/S2 tokens and FIFO contents are discarded. No response is produced for them.

Decomposition:
- Package sa_ram_rd_pkg holds:
  - default DW/AW/RAM_DEPTH constants
  - the struct {err, data} for FIFO entries
- One sub-module: sa_ram_rd_skid_fifo (parameterised sync FIFO with count output, fall-through handled in the parent).

Test Plan:
1. Preload RAM[3]=0xA5.., hold rsp_ready=1, single request addr=3 at cycle 10 -> ram_re=1 at cycle 10, ram_ore=1 at cycle 11, rsp_valid=1 with data 0xA5.. at cycle 12, rsp_err=0.
2. Back-to-back requests addr 0..18, rsp_ready=1 -> 19 responses on consecutive cycles in address order; req_ready never drops.
3. rsp_ready=0 while streaming -> exactly 4 requests accepted, then req_ready=0; after rsp_ready=1 all 4 drain in order and req_ready recovers.
4. Request addr=19 between addr=2 and addr=5 -> no ram_re in its cycle; middle response has rsp_err=1 and data=0; neighbours are correct.
5. Toggle rsp_ready randomly every cycle over 200 requests -> scoreboard match, no loss or duplication, rsp_data stable while valid&!ready.
6. Assert reset with 2 in flight and 2 in the FIFO -> next cycle rsp_valid=0, ram_ore=0; a post-reset request returns correct data with 2-cycle latency.
